// File: rtl/product_accumulator.sv
// Product accumulator: sums each group of LEN multiplier products arriving over
// valid/ready and presents every completed sum on a held valid/ready port.
module product_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned LEN    = 4,
    parameter int unsigned ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned CNT_W   = (LEN > 2) ? $clog2(LEN) : 1;
    localparam int unsigned FRAME_W = 8;

    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_DONE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ACC_W-1:0]   r_sum;
    logic [ACC_W-1:0]   w_sum_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [FRAME_W-1:0] w_frame_cnt_nxt;

    logic               w_in_fire;
    logic               w_out_fire;
    logic [ACC_W-1:0]   w_acc_add;

    // Ready is derived straight from the state so upstream sees it without a bubble.
    assign in_ready   = (r_state == S_ACC);
    assign w_in_fire  = in_valid && (r_state == S_ACC);
    assign w_out_fire = r_out_valid && out_ready;
    assign w_acc_add  = r_acc + ACC_W'(product);

    // State and datapath register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sum       <= w_sum_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // Next-state logic; clear wins over any coincident transfer or handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_sum_nxt       = r_sum;
        w_out_valid_nxt = r_out_valid;
        w_frame_cnt_nxt = r_frame_cnt;

        if (clear) begin
            w_state_nxt     = S_ACC;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_in_fire) begin
                        if (r_cnt == CNT_LAST) begin
                            w_sum_nxt       = w_acc_add;
                            w_out_valid_nxt = 1'b1;
                            w_acc_nxt       = '0;
                            w_cnt_nxt       = '0;
                            w_state_nxt     = S_DONE;
                        end else begin
                            w_acc_nxt = w_acc_add;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (w_out_fire) begin
                        w_out_valid_nxt = 1'b0;
                        w_frame_cnt_nxt = r_frame_cnt + FRAME_W'(1);
                        w_state_nxt     = S_ACC;
                    end
                end
                default: begin
                    w_state_nxt = S_ACC;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed testbench for product_accumulator with hand-computed expected sums.
module tb_product_accumulator;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned LEN    = 4;
    localparam int unsigned ACC_W  = 18;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum;
    logic [7:0]        frame_cnt;

    int n_checks;
    int n_errors;

    product_accumulator #(
        .PROD_W(PROD_W),
        .LEN   (LEN),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .product  (product),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one product and wait (bounded) until it is transferred.
    task automatic push(input logic [PROD_W-1:0] p);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        product  = p;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        product   = '0;
        out_ready = 1'b1;

        // Reset values
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic frame with immediate acceptance
        push(16'd36);
        push(16'd105);
        push(16'd100);
        push(16'd65025);
        check("f1_out_valid", 32'(out_valid), 32'd1);
        check("f1_sum",       32'(sum),       32'd65266);
        check("f1_in_ready",  32'(in_ready),  32'd0);
        step();
        check("f1_out_valid_drop", 32'(out_valid), 32'd0);
        check("f1_frame_cnt",      32'(frame_cnt), 32'd1);
        check("f1_in_ready_back",  32'(in_ready),  32'd1);

        // Max values under backpressure; extra product offered but not taken
        out_ready = 1'b0;
        repeat (4) push(16'd65025);
        in_valid = 1'b1;
        product  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum",       32'(sum),       32'd260100);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_out_valid_drop", 32'(out_valid), 32'd0);
        check("bp_frame_cnt",      32'(frame_cnt), 32'd2);

        // Clear discards a partial frame
        push(16'd36);
        push(16'd105);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (4) push(16'd1);
        check("clr_sum",       32'(sum),       32'd4);
        check("clr_out_valid", 32'(out_valid), 32'd1);
        step();
        check("clr_frame_cnt", 32'(frame_cnt), 32'd3);

        // Clear with a coincident handshake in S_DONE
        out_ready = 1'b0;
        repeat (4) push(16'd3);
        check("clr2_sum_pending", 32'(sum), 32'd12);
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        check("clr2_out_valid", 32'(out_valid), 32'd0);
        check("clr2_frame_cnt", 32'(frame_cnt), 32'd3);
        check("clr2_sum_held",  32'(sum),       32'd12);
        check("clr2_in_ready",  32'(in_ready),  32'd1);

        // Asynchronous reset mid-frame
        repeat (3) push(16'd9);
        #1 rst = 1'b1;
        #2;
        check("amid_out_valid", 32'(out_valid), 32'd0);
        check("amid_sum",       32'(sum),       32'd0);
        check("amid_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        step();
        repeat (4) push(16'd2);
        check("amid_new_sum", 32'(sum), 32'd8);
        step();
        check("amid_frame_cnt_1", 32'(frame_cnt), 32'd1);

        // 256 frames with gaps between products; counter wraps to zero
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 4; k++) begin
                push(16'd1);
                if (k < 3) step();
            end
            check("wrap_sum", 32'(sum), 32'd4);
            step();
            if (f == 254) check("wrap_frame_255", 32'(frame_cnt), 32'd255);
        end
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
